drum_voice_ctrl: RTL
====================

Name: drum_voice_ctrl

Overview:
Upstream control stage for the kick/tom drum voice. It accepts note-on events from the MIDI decoder at any time and maps General MIDI drum note numbers to a kick/tom mode. On each sample tick it runs one drum frame through the start/finish handshake and registers the resulting 24-bit sample for the mixer. It also detects sample ticks that arrive before the previous frame has finished.

Parameters:
CNT_W, 8, width of the saturating overrun counter

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
sample_tick  in  1  one-cycle audio-rate strobe
note_valid  in  1  note-on event strobe
note_num  in  7  MIDI note number
note_vel  in  7  MIDI velocity; 0 means note-off
drum_start  out  1  frame start to drum voice
drum_trigger  out  1  retrigger flag for this frame
drum_mode  out  2  00 kick, 01 low tom, 10 mid tom, 11 high tom
drum_finish  in  1  frame done from drum voice
drum_wave  in  24  drum sample, valid while drum_finish=1
sample_out  out  24  registered signed sample
sample_valid  out  1  one-cycle strobe, new sample_out
busy  out  1  frame in progress
overrun  out  1  sticky flag, a tick was dropped
overrun_cnt  out  CNT_W  saturating count of dropped ticks
overrun_clr  in  1  clears overrun and overrun_cnt

Behaviour:
- Reset (async assert, sync release):
  - State IDLE; pending cleared.
  - drum_mode=00, drum_start=0, drum_trigger=0.
  - sample_out=0, sample_valid=0, overrun=0, overrun_cnt=0.
  - The drum voice must be reset in the same domain.
- Note acceptance: an event is accepted when note_valid=1, note_vel!=0 and the note is mapped.
  - Note map: 35,36→00; 41,43→01; 45,47→10; 48,50→11. All other notes are ignored.
  - An accepted event sets pend_valid=1 and pend_mode=mapped mode.
  - If several events arrive before the next launch, the last one wins.
- State machine:
  - IDLE: when sample_tick=1, go to LAUNCH.
  - LAUNCH: lasts exactly 1 cycle.
    - drum_start=1 and drum_trigger=pend_valid.
    - If pend_valid=1, drum_mode takes pend_mode on the same cycle and holds it until the next triggered launch. drum_mode never changes between triggers, so tom pitch stays stable during decay.
    - pend_valid is cleared.
    - Go to WAIT.
  - WAIT: when drum_finish=1, capture sample_out<=drum_wave and go to IDLE. sample_valid=1 on the following cycle only.
- busy=1 in LAUNCH and WAIT.
- drum_start is never asserted outside LAUNCH. This prevents an immediate re-run when the voice returns to its idle state.
- Latency:
  - Launch: tick at cycle T → drum_start at T+1.
  - Output: drum_finish at cycle F → sample_valid at F+1.
- Simultaneous note event and launch:
  - A note accepted in the LAUNCH cycle is not used for that frame. It stays pending for the next frame.
  - A note accepted in the same cycle as the IDLE tick is used for the frame that tick launches.
- Overrun:
  - A sample_tick while busy is dropped: overrun<=1 and overrun_cnt increments, saturating at all-ones.
  - If overrun_clr and a dropped tick occur in the same cycle, the set/increment wins and overrun_cnt becomes 1.
- A sample_tick in the same cycle as drum_finish in WAIT is still an overrun. No launch is queued.
- Reset asserted mid-frame: abort immediately; the in-flight sample is discarded.

Decomposition:
- Package drum_pkg:
  - drum_mode_t enum (KICK, TOM_LO, TOM_MID, TOM_HI).
  - Note-number localparams.
  - Function note_to_mode returning {hit, mode}.
- Sub-module drum_note_latch, ~60 lines:
  - Contents: note filter, map, and the pend_valid/pend_mode register.
  - Ports: note inputs, take strobe, pend outputs.
- The FSM, overrun logic and output register stay in the top module.

Test Plan:
- Note 36 vel 100, then a tick → LAUNCH with drum_start=1, drum_trigger=1, drum_mode=00. Next tick (no note) → drum_trigger=0, drum_mode stays 00.
- Note 45 then note 50 before one tick → a single launch with drum_mode=11. Note 60 or note 45 vel 0 → no trigger, mode unchanged.
- Model drum_finish 13 cycles after start with drum_wave=24'h800001 → sample_out=24'h800001 and a 1-cycle sample_valid at finish+1; busy for 14 cycles.
- Tick while in WAIT → overrun=1, overrun_cnt=1, no extra launch. 300 dropped ticks with CNT_W=8 → overrun_cnt=255. Clear and drop in the same cycle → overrun_cnt=1.
- Note 41 in the LAUNCH cycle of a frame → that frame has drum_trigger=0; the next frame has drum_trigger=1, drum_mode=01.
- rst_n low during WAIT → outputs return to reset values immediately; no sample_valid after release; pending note lost.

Source files
------------

// File: rtl/drum_pkg.sv
// Shared types and the General MIDI drum-note map for the kick/tom voice controller.
package drum_pkg;

   typedef enum logic [1:0] {
      KICK    = 2'b00,
      TOM_LO  = 2'b01,
      TOM_MID = 2'b10,
      TOM_HI  = 2'b11
   } drum_mode_t;

   typedef enum logic [1:0] {
      S_IDLE,
      S_LAUNCH,
      S_WAIT
   } drum_state_t;

   localparam logic [6:0] NOTE_KICK_AC  = 7'd35;
   localparam logic [6:0] NOTE_KICK_1   = 7'd36;
   localparam logic [6:0] NOTE_TOM_LO_F = 7'd41;
   localparam logic [6:0] NOTE_TOM_LO   = 7'd43;
   localparam logic [6:0] NOTE_TOM_MD_L = 7'd45;
   localparam logic [6:0] NOTE_TOM_MD_H = 7'd47;
   localparam logic [6:0] NOTE_TOM_HI_L = 7'd48;
   localparam logic [6:0] NOTE_TOM_HI_H = 7'd50;

   // Returns {hit, mode}; hit is 0 for any note this voice does not play.
   function automatic logic [2:0] note_to_mode(input logic [6:0] note);
      logic [2:0] result;
      result = {1'b0, KICK};
      case (note)
         NOTE_KICK_AC,  NOTE_KICK_1:   result = {1'b1, KICK};
         NOTE_TOM_LO_F, NOTE_TOM_LO:   result = {1'b1, TOM_LO};
         NOTE_TOM_MD_L, NOTE_TOM_MD_H: result = {1'b1, TOM_MID};
         NOTE_TOM_HI_L, NOTE_TOM_HI_H: result = {1'b1, TOM_HI};
         default:                      result = {1'b0, KICK};
      endcase
      return result;
   endfunction

endpackage

// File: rtl/drum_note_latch.sv
// Filters note-on events, maps them to a drum mode and holds the most recent one
// until the controller takes it at frame launch.
module drum_note_latch
   import drum_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic       i_note_valid,
   input  logic [6:0] i_note_num,
   input  logic [6:0] i_note_vel,
   input  logic       i_take,
   output logic       o_pend_valid,
   output drum_mode_t o_pend_mode
);

   logic [2:0] w_map;
   logic       w_accept;
   logic       r_pend_valid;
   drum_mode_t r_pend_mode;

   always_comb begin
      w_map    = note_to_mode(i_note_num);
      w_accept = i_note_valid && (i_note_vel != 7'd0) && w_map[2];
   end

   // A note arriving on the take cycle wins, so it survives for the next frame.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_pend_valid <= 1'b0;
         r_pend_mode  <= KICK;
      end else if (w_accept) begin
         r_pend_valid <= 1'b1;
         r_pend_mode  <= drum_mode_t'(w_map[1:0]);
      end else if (i_take) begin
         r_pend_valid <= 1'b0;
      end
   end

   assign o_pend_valid = r_pend_valid;
   assign o_pend_mode  = r_pend_mode;

endmodule

// File: rtl/drum_voice_ctrl.sv
// Frame sequencer for the kick/tom voice: launches one frame per sample tick,
// registers the finished sample and counts ticks dropped while a frame is running.
module drum_voice_ctrl
   import drum_pkg::*;
#(
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             sample_tick,
   input  logic             note_valid,
   input  logic [6:0]       note_num,
   input  logic [6:0]       note_vel,
   output logic             drum_start,
   output logic             drum_trigger,
   output logic [1:0]       drum_mode,
   input  logic             drum_finish,
   input  logic [23:0]      drum_wave,
   output logic [23:0]      sample_out,
   output logic             sample_valid,
   output logic             busy,
   output logic             overrun,
   output logic [CNT_W-1:0] overrun_cnt,
   input  logic             overrun_clr
);

   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   drum_state_t      r_state;
   drum_state_t      w_next;
   drum_mode_t       r_mode;
   drum_mode_t       w_pend_mode;
   logic             w_pend_valid;
   logic             w_launch;
   logic             w_capture;
   logic             w_drop;
   logic [23:0]      r_sample;
   logic             r_sample_valid;
   logic             r_overrun;
   logic [CNT_W-1:0] r_cnt;

   drum_note_latch u_note_latch (
      .clk          (clk),
      .rst_n        (rst_n),
      .i_note_valid (note_valid),
      .i_note_num   (note_num),
      .i_note_vel   (note_vel),
      .i_take       (w_launch),
      .o_pend_valid (w_pend_valid),
      .o_pend_mode  (w_pend_mode)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_next;
   end

   always_comb begin
      w_next    = r_state;
      w_launch  = 1'b0;
      w_capture = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (sample_tick) w_next = S_LAUNCH;
         end
         S_LAUNCH: begin
            w_launch = 1'b1;
            w_next   = S_WAIT;
         end
         S_WAIT: begin
            if (drum_finish) begin
               w_capture = 1'b1;
               w_next    = S_IDLE;
            end
         end
         default: w_next = S_IDLE;
      endcase
   end

   assign w_drop = sample_tick && (r_state != S_IDLE);

   // The mode only moves on a triggered launch so tom pitch is stable through the decay.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                        r_mode <= KICK;
      else if (w_launch && w_pend_valid) r_mode <= w_pend_mode;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sample       <= 24'd0;
         r_sample_valid <= 1'b0;
      end else begin
         r_sample_valid <= w_capture;
         if (w_capture) r_sample <= drum_wave;
      end
   end

   // A dropped tick outranks a clear so the event that caused it is never lost.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_overrun <= 1'b0;
         r_cnt     <= '0;
      end else if (w_drop) begin
         r_overrun <= 1'b1;
         if (overrun_clr)          r_cnt <= CNT_ONE;
         else if (r_cnt != CNT_MAX) r_cnt <= r_cnt + CNT_ONE;
      end else if (overrun_clr) begin
         r_overrun <= 1'b0;
         r_cnt     <= '0;
      end
   end

   assign drum_start   = w_launch;
   assign drum_trigger = w_launch && w_pend_valid;
   assign drum_mode    = (w_launch && w_pend_valid) ? w_pend_mode : r_mode;
   assign busy         = (r_state != S_IDLE);
   assign sample_out   = r_sample;
   assign sample_valid = r_sample_valid;
   assign overrun      = r_overrun;
   assign overrun_cnt  = r_cnt;

endmodule
